// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard/forwarding unit.
//   REG_AW_DEFAULT   default register address width
//   FWD_*            {control1, control2} encodings of the EX operand muxes
//   pipe_slot_t      in-flight instruction record at the default width
package hazard_forward_unit_pkg;

   localparam int REG_AW_DEFAULT = 6;

   // {c1,c2}: 00 regfile, 10 EX/MEM result, x1 MEM/WB result
   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b10;
   localparam logic [1:0] FWD_MEMWB   = 2'b01;

   typedef struct packed {
      logic                      valid;
      logic [REG_AW_DEFAULT-1:0] rd;
      logic                      wr;
      logic                      load;
   } pipe_slot_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Forwarding select for one EX operand mux (purely combinational).
//   src, used          source register of the instruction in ID, and whether it is read
//   ex_live/rd/load    youngest in-flight producer (instruction currently in EX)
//   mem_live/rd        older in-flight producer (instruction currently in MEM)
//   sel                {control1, control2} to be registered for the next cycle
module fwd_select
   import hazard_forward_unit_pkg::*;
#(
   parameter int AW = REG_AW_DEFAULT
) (
   input  logic [AW-1:0] src,
   input  logic          used,
   input  logic          ex_live,
   input  logic [AW-1:0] ex_rd,
   input  logic          ex_load,
   input  logic          mem_live,
   input  logic [AW-1:0] mem_rd,
   output logic [1:0]    sel
);

   logic c1;
   logic c2;

   always_comb begin
      // A load in EX has no result yet on the EX/MEM path; that case is
      // handled by the stall, after which the load is seen from MEM.
      c1  = used & ex_live & (ex_rd == src) & ~ex_load;
      // The younger producer wins, so MEM only forwards when EX does not.
      c2  = used & mem_live & (mem_rd == src) & ~c1;
      sel = FWD_REGFILE;
      if (c1) begin
         sel = FWD_EXMEM;
      end else if (c2) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding control between decode and EX.
// Tracks the destinations of the instructions in EX and MEM, stalls ID on a
// load-use hazard, and registers the operand mux selects so they are valid
// during the cycle the consuming instruction sits in EX.
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid                        ID holds a real instruction
//   id_rs/id_rt, id_rs_used/rt_used source addresses and read enables
//   id_rd, id_wr_en, id_is_load     destination, write enable, load flag
//   flush                           squash the ID instruction
//   stall                           hold PC and IF/ID (combinational)
//   a_ctrl1/2, b_ctrl1/2            registered operand mux selects
//   stall_cnt                       saturating count of load-use stall cycles
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
#(
   parameter int REG_AW   = REG_AW_DEFAULT,
   parameter bit ZERO_REG = 1'b1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_wr_en,
   input  logic              id_is_load,
   input  logic              flush,
   output logic              stall,
   output logic              a_ctrl1,
   output logic              a_ctrl2,
   output logic              b_ctrl1,
   output logic              b_ctrl2,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Same layout as pipe_slot_t, sized by this instance's REG_AW.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              wr;
      logic              load;
   } slot_t;

   slot_t      ex_q;
   slot_t      mem_q;
   slot_t      ex_d;
   logic       ex_live;
   logic       mem_live;
   logic       hazard;
   logic       issue;
   logic [1:0] a_sel;
   logic [1:0] b_sel;
   logic [1:0] a_q;
   logic [1:0] b_q;

   // A slot only produces a forwardable value if it really writes a register
   // other than the hard-wired zero register.
   always_comb begin
      ex_live  = ex_q.valid  & ex_q.wr  & ~(ZERO_REG && (ex_q.rd  == '0));
      mem_live = mem_q.valid & mem_q.wr & ~(ZERO_REG && (mem_q.rd == '0));
   end

   always_comb begin
      hazard = ex_live & ex_q.load &
               ((id_rs_used & (id_rs == ex_q.rd)) | (id_rt_used & (id_rt == ex_q.rd)));
      // A flushed instruction never consumes anything, so it never stalls.
      stall  = id_valid & ~flush & hazard;
      issue  = id_valid & ~flush & ~stall;

      ex_d = '0;
      if (issue) begin
         ex_d.valid = 1'b1;
         ex_d.rd    = id_rd;
         ex_d.wr    = id_wr_en;
         ex_d.load  = id_is_load;
      end
   end

   fwd_select #(.AW(REG_AW)) u_sel_a (
      .src      (id_rs),
      .used     (id_rs_used),
      .ex_live  (ex_live),
      .ex_rd    (ex_q.rd),
      .ex_load  (ex_q.load),
      .mem_live (mem_live),
      .mem_rd   (mem_q.rd),
      .sel      (a_sel)
   );

   fwd_select #(.AW(REG_AW)) u_sel_b (
      .src      (id_rt),
      .used     (id_rt_used),
      .ex_live  (ex_live),
      .ex_rd    (ex_q.rd),
      .ex_load  (ex_q.load),
      .mem_live (mem_live),
      .mem_rd   (mem_q.rd),
      .sel      (b_sel)
   );

   // The selects are computed against the current EX/MEM slots; after this
   // edge the current EX instruction is the one whose result sits on EX/MEM
   // and the current MEM instruction sits on MEM/WB, matching the mux inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         a_q   <= FWD_REGFILE;
         b_q   <= FWD_REGFILE;
      end else begin
         mem_q <= ex_q;
         ex_q  <= ex_d;
         a_q   <= issue ? a_sel : FWD_REGFILE;
         b_q   <= issue ? b_sel : FWD_REGFILE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign a_ctrl1 = a_q[1];
   assign a_ctrl2 = a_q[0];
   assign b_ctrl1 = b_q[1];
   assign b_ctrl2 = b_q[0];

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [5:0]  id_rs;
   logic [5:0]  id_rt;
   logic        id_rs_used;
   logic        id_rt_used;
   logic [5:0]  id_rd;
   logic        id_wr_en;
   logic        id_is_load;
   logic        flush;
   logic        stall;
   logic        a_ctrl1;
   logic        a_ctrl2;
   logic        b_ctrl1;
   logic        b_ctrl2;
   logic [15:0] stall_cnt;
   logic        s_stall;
   logic        s_a_ctrl1;
   logic        s_a_ctrl2;
   logic        s_b_ctrl1;
   logic        s_b_ctrl2;
   logic [1:0]  s_stall_cnt;

   int n_pass  = 0;
   int n_total = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   hazard_forward_unit dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
      .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush), .stall(stall),
      .a_ctrl1(a_ctrl1), .a_ctrl2(a_ctrl2), .b_ctrl1(b_ctrl1), .b_ctrl2(b_ctrl2),
      .stall_cnt(stall_cnt)
   );

   // Narrow-counter instance sharing the same stimulus, for saturation.
   hazard_forward_unit #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
      .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush), .stall(s_stall),
      .a_ctrl1(s_a_ctrl1), .a_ctrl2(s_a_ctrl2), .b_ctrl1(s_b_ctrl1), .b_ctrl2(s_b_ctrl2),
      .stall_cnt(s_stall_cnt)
   );

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int sat(input int v, input int max);
      return (v > max) ? max : v;
   endfunction

   // ---------------- vectors ----------------
   typedef struct {
      logic       v;
      logic [5:0] rs;
      logic [5:0] rt;
      logic       ru;
      logic       tu;
      logic [5:0] rd;
      logic       wr;
      logic       ld;
      logic       fl;
      logic       es;
      logic [1:0] ea;
      logic [1:0] eb;
      int         ec;
   } vec_t;

   function automatic vec_t mk(input logic v, input int rs, input int rt, input logic ru,
                               input logic tu, input int rd, input logic wr, input logic ld,
                               input logic fl, input logic es, input logic [1:0] ea,
                               input logic [1:0] eb, input int ec);
      vec_t t;
      t.v = v; t.rs = 6'(rs); t.rt = 6'(rt); t.ru = ru; t.tu = tu; t.rd = 6'(rd);
      t.wr = wr; t.ld = ld; t.fl = fl; t.es = es; t.ea = ea; t.eb = eb; t.ec = ec;
      return t;
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input vec_t t);
      id_valid   = t.v;
      id_rs      = t.rs;
      id_rt      = t.rt;
      id_rs_used = t.ru;
      id_rt_used = t.tu;
      id_rd      = t.rd;
      id_wr_en   = t.wr;
      id_is_load = t.ld;
      flush      = t.fl;
   endtask

   task automatic apply(input vec_t t, input string tag);
      @(negedge clk);
      drive(t);
      #1;
      check({tag, " stall"}, 32'(stall), 32'(t.es));
      check({tag, " stall_sat"}, 32'(s_stall), 32'(t.es));
      @(posedge clk);
      #1;
      check({tag, " a_ctrl"}, 32'({a_ctrl1, a_ctrl2}), 32'(t.ea));
      check({tag, " b_ctrl"}, 32'({b_ctrl1, b_ctrl2}), 32'(t.eb));
      check({tag, " stall_cnt"}, 32'(stall_cnt), 32'(t.ec));
      check({tag, " stall_cnt_sat"}, 32'(s_stall_cnt), 32'(sat(t.ec, 3)));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " stall"}, 32'(stall), 0);
      check({tag, " a_ctrl"}, 32'({a_ctrl1, a_ctrl2}), 0);
      check({tag, " b_ctrl"}, 32'({b_ctrl1, b_ctrl2}), 0);
      check({tag, " stall_cnt"}, 32'(stall_cnt), 0);
      check({tag, " stall_cnt_sat"}, 32'(s_stall_cnt), 0);
   endtask

   // ---------------- reference model ----------------
   // Recent issue history, youngest first: destination register that will
   // really be written (-1 for none) and whether it comes from a load.
   typedef struct {
      int dst;
      bit load;
   } hist_t;
   hist_t hist[$];
   int    m_cnt;

   function automatic int live_dst(input bit v, input bit wr, input int rd);
      return (v && wr && rd != 0) ? rd : -1;
   endfunction

   function automatic logic [1:0] model_sel(input bit used, input int src);
      if (used && hist[0].dst == src && !hist[0].load) return 2'b10;
      if (used && hist[1].dst == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit model_stall(input bit v, input bit fl, input bit ru, input int rs,
                                      input bit tu, input int rt);
      if (!v || fl || !hist[0].load || hist[0].dst < 0) return 1'b0;
      return (ru && rs == hist[0].dst) || (tu && rt == hist[0].dst);
   endfunction

   task automatic model_reset();
      hist_t b;
      b.dst = -1;
      b.load = 1'b0;
      hist.delete();
      hist.push_back(b);
      hist.push_back(b);
      m_cnt = 0;
   endtask

   // ---------------- stimulus ----------------
   vec_t vecs[$];

   initial begin
      vec_t  t;
      hist_t h;
      bit    es;
      bit    iss;
      logic [1:0] ea;
      logic [1:0] eb;

      rst_n = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // v  rs rt ru tu rd wr ld fl | stall a     b     cnt
      vecs.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0)); // add r3
      vecs.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 2'b10, 2'b00, 0)); // add r4,r3,r5
      vecs.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0)); // add r3
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0)); // nop
      vecs.push_back(mk(1, 1, 3, 1, 1, 6, 1, 0, 0, 0, 2'b00, 2'b01, 0)); // sub r6,r1,r3
      vecs.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0)); // add r3
      vecs.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0)); // add r3
      vecs.push_back(mk(1, 3, 3, 1, 1, 9, 1, 0, 0, 0, 2'b10, 2'b10, 0)); // add r9,r3,r3
      vecs.push_back(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 0)); // lw r7
      vecs.push_back(mk(1, 7, 2, 1, 1, 8, 1, 0, 0, 1, 2'b00, 2'b00, 1)); // add r8,r7,r2 stall
      vecs.push_back(mk(1, 7, 2, 1, 1, 8, 1, 0, 0, 0, 2'b01, 2'b00, 1)); // reissue
      vecs.push_back(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 1)); // lw r7
      vecs.push_back(mk(1, 7, 2, 1, 1, 8, 1, 0, 1, 0, 2'b00, 2'b00, 1)); // flushed use
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1)); // nop
      vecs.push_back(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // add r0
      vecs.push_back(mk(1, 0, 0, 1, 1, 10, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // add r10,r0,r0
      vecs.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1)); // lw r0
      vecs.push_back(mk(1, 0, 5, 1, 1, 11, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // add r11,r0,r5

      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      // Repeated load-use stalls: wide counter keeps counting, narrow one saturates.
      for (int k = 0; k < 4; k++) begin
         apply(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 1 + k), $sformatf("sat%0d lw", k));
         apply(mk(1, 7, 2, 1, 1, 8, 1, 0, 0, 1, 2'b00, 2'b00, 2 + k), $sformatf("sat%0d stall", k));
         apply(mk(1, 7, 2, 1, 1, 8, 1, 0, 0, 0, 2'b01, 2'b00, 2 + k), $sformatf("sat%0d use", k));
      end

      // Asynchronous reset while a stall is being asserted.
      apply(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 5), "midrst lw");
      @(negedge clk);
      drive(mk(1, 7, 2, 1, 1, 8, 1, 0, 0, 1, 2'b00, 2'b00, 5));
      #1;
      check("midrst stall before", 32'(stall), 1);
      rst_n = 1'b0;
      #1;
      check_reset_state("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Randomized traffic against the history model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         t = mk($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 9) == 0, 0, 2'b00, 2'b00, 0);
         drive(t);
         #1;
         es  = model_stall(t.v, t.fl, t.ru, int'(t.rs), t.tu, int'(t.rt));
         iss = t.v && !t.fl && !es;
         ea  = iss ? model_sel(t.ru, int'(t.rs)) : 2'b00;
         eb  = iss ? model_sel(t.tu, int'(t.rt)) : 2'b00;
         if (es) m_cnt++;
         check($sformatf("rnd%0d stall", i), 32'(stall), 32'(es));
         @(posedge clk);
         #1;
         h.dst  = iss ? live_dst(t.v, t.wr, int'(t.rd)) : -1;
         h.load = iss && t.ld;
         hist.push_front(h);
         hist = hist[0:1];
         check($sformatf("rnd%0d a_ctrl", i), 32'({a_ctrl1, a_ctrl2}), 32'(ea));
         check($sformatf("rnd%0d b_ctrl", i), 32'({b_ctrl1, b_ctrl2}), 32'(eb));
         check($sformatf("rnd%0d stall_cnt", i), 32'(stall_cnt), 32'(sat(m_cnt, 65535)));
         check($sformatf("rnd%0d stall_cnt_sat", i), 32'(s_stall_cnt), 32'(sat(m_cnt, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
